// File: rtl/asy_fifo_pkg.sv
`default_nettype none
// ============================================================================
// Module   : asy_fifo_pkg
// Brief    : Shared defaults and pointer type for the single-clock byte FIFO.
// Revision : 1.0 - initial release
// ============================================================================
package asy_fifo_pkg;

    localparam int DATA_WIDTH_DEF = 8;
    localparam int ADDR_WIDTH_DEF = 4;

    // Extra MSB is the wrap bit that distinguishes full from empty
    typedef logic [ADDR_WIDTH_DEF:0] ptr_t;

endpackage : asy_fifo_pkg
`default_nettype wire

// File: rtl/asy_fifo_mem.sv
`default_nettype none
// ============================================================================
// Module   : asy_fifo_mem
// Brief    : DEPTH x DATA_WIDTH register array, one write port, registered read port.
// Revision : 1.0 - initial release
// ============================================================================
module asy_fifo_mem
    import asy_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  wr_en_i,
    input  logic [ADDR_WIDTH-1:0] wr_addr_i,
    input  logic [DATA_WIDTH-1:0] wr_data_i,
    input  logic                  rd_en_i,
    input  logic [ADDR_WIDTH-1:0] rd_addr_i,
    output logic [DATA_WIDTH-1:0] rd_data_o
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] rd_data_q;

    // Storage is intentionally not reset; only the output register is
    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rd_data_q <= '0;
        end else if (rd_en_i) begin
            rd_data_q <= mem_q[rd_addr_i];
        end
    end

    assign rd_data_o = rd_data_q;

endmodule : asy_fifo_mem
`default_nettype wire

// File: rtl/asy_fifo_core.sv
`default_nettype none
// ============================================================================
// Module   : asy_fifo_core
// Brief    : Single-clock FIFO with full/empty flags; ASY_FIFO_LEVEL_EN adds fifo_level.
// Revision : 1.0 - initial release
// ============================================================================
module asy_fifo_core
    import asy_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
    input  logic                  wr_clk,
    input  logic                  wr_rst,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] rd_data,
`ifdef ASY_FIFO_LEVEL_EN
    output logic [ADDR_WIDTH:0]   fifo_level,
`endif
    output logic                  fifo_Full,
    output logic                  fifo_Empty
);

    logic [ADDR_WIDTH:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH:0] rd_ptr_q, rd_ptr_d;
    logic                wr_fire;
    logic                rd_fire;

    assign fifo_Empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_Full  = (wr_ptr_q[ADDR_WIDTH] != rd_ptr_q[ADDR_WIDTH]) &&
                        (wr_ptr_q[ADDR_WIDTH-1:0] == rd_ptr_q[ADDR_WIDTH-1:0]);

    // Gating uses pre-edge flags, so full+both reads only and empty+both writes only
    assign wr_fire = wr_en && !fifo_Full;
    assign rd_fire = rd_en && !fifo_Empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (wr_fire) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (rd_fire) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge wr_clk) begin
        if (wr_rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

`ifdef ASY_FIFO_LEVEL_EN
    assign fifo_level = wr_ptr_q - rd_ptr_q;
`endif

    asy_fifo_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_mem (
        .clk_i     (wr_clk),
        .rst_i     (wr_rst),
        .wr_en_i   (wr_fire),
        .wr_addr_i (wr_ptr_q[ADDR_WIDTH-1:0]),
        .wr_data_i (wr_data),
        .rd_en_i   (rd_fire),
        .rd_addr_i (rd_ptr_q[ADDR_WIDTH-1:0]),
        .rd_data_o (rd_data)
    );

endmodule : asy_fifo_core
`default_nettype wire

// File: tb/tb_asy_fifo_core.sv
`default_nettype none
// ============================================================================
// Module   : tb_asy_fifo_core
// Brief    : Directed plus randomized bench for asy_fifo_core against a queue model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_asy_fifo_core;

    localparam int DEPTH = 16;

    logic       wr_clk;
    logic       wr_rst;
    logic       wr_en;
    logic [7:0] wr_data;
    logic       rd_en;
    logic [7:0] rd_data;
    logic       fifo_Full;
    logic       fifo_Empty;
`ifdef ASY_FIFO_LEVEL_EN
    logic [4:0] fifo_level;
`endif

    asy_fifo_core dut (
        .wr_clk     (wr_clk),
        .wr_rst     (wr_rst),
        .wr_en      (wr_en),
        .wr_data    (wr_data),
        .rd_en      (rd_en),
        .rd_data    (rd_data),
`ifdef ASY_FIFO_LEVEL_EN
        .fifo_level (fifo_level),
`endif
        .fifo_Full  (fifo_Full),
        .fifo_Empty (fifo_Empty)
    );

    initial wr_clk = 1'b0;
    always #5 wr_clk = ~wr_clk;

    int         n_checks = 0;
    int         n_errors = 0;
    logic [7:0] model_q[$];
    logic [7:0] exp_rd = 8'h00;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // One clock: drive, let the edge happen, update the reference, then compare
    task automatic step(input logic rst, input logic wr, input logic [7:0] d, input logic rd);
        bit was_full, was_empty;
        wr_rst  = rst;
        wr_en   = wr;
        wr_data = d;
        rd_en   = rd;
        @(posedge wr_clk);
        was_full  = (model_q.size() == DEPTH);
        was_empty = (model_q.size() == 0);
        if (rst) begin
            model_q.delete();
            exp_rd = 8'h00;
        end else begin
            if (rd && !was_empty) exp_rd = model_q.pop_front();
            if (wr && !was_full)  model_q.push_back(d);
        end
        #1;
        chk("rd_data", 32'(rd_data), 32'(exp_rd));
        chk("full", 32'(fifo_Full), 32'(model_q.size() == DEPTH));
        chk("empty", 32'(fifo_Empty), 32'(model_q.size() == 0));
`ifdef ASY_FIFO_LEVEL_EN
        chk("level", 32'(fifo_level), 32'(model_q.size()));
`endif
        wr_rst = 1'b0;
        wr_en  = 1'b0;
        rd_en  = 1'b0;
    endtask

    initial begin
        int wr_pct, rd_pct;
        wr_rst  = 1'b1;
        wr_en   = 1'b0;
        rd_en   = 1'b0;
        wr_data = 8'h00;

        // Reset held two cycles
        step(1'b1, 1'b0, 8'h00, 1'b0);
        step(1'b1, 1'b0, 8'h00, 1'b0);

        // Fill to full, then one dropped write
        for (int i = 1; i <= 16; i++) step(1'b0, 1'b1, 8'(i), 1'b0);
        step(1'b0, 1'b1, 8'hAA, 1'b0);

        // Drain in order, then an extra read on empty
        for (int i = 0; i < 16; i++) step(1'b0, 1'b0, 8'h00, 1'b1);
        step(1'b0, 1'b0, 8'h00, 1'b1);
        chk("hold_after_empty", 32'(rd_data), 32'h10);

        // Pointer wrap
        for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 8'h30 + 8'(i), 1'b0);
        for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 8'h00, 1'b1);
        for (int i = 0; i < 12; i++) step(1'b0, 1'b1, 8'h20 + 8'(i), 1'b0);
        for (int i = 0; i < 12; i++) step(1'b0, 1'b0, 8'h00, 1'b1);

        // Simultaneous read/write with 5 stored, then at full, then at empty
        for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 8'h40 + 8'(i), 1'b0);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 8'h50 + 8'(i), 1'b1);
        chk("occ_5_flags", 32'({fifo_Full, fifo_Empty}), 32'h0);
        for (int i = 0; i < 11; i++) step(1'b0, 1'b1, 8'h60 + 8'(i), 1'b0);
        step(1'b0, 1'b1, 8'hEE, 1'b1);
        for (int i = 0; i < 15; i++) step(1'b0, 1'b0, 8'h00, 1'b1);
        step(1'b0, 1'b1, 8'h77, 1'b1);
        step(1'b0, 1'b0, 8'h00, 1'b1);

        // Mid-operation reset
        for (int i = 0; i < 7; i++) step(1'b0, 1'b1, 8'h70 + 8'(i), 1'b0);
        step(1'b1, 1'b0, 8'h00, 1'b0);
        step(1'b0, 1'b1, 8'h55, 1'b0);
        step(1'b0, 1'b0, 8'h00, 1'b1);
        chk("post_reset_read", 32'(rd_data), 32'h55);

        // Randomized traffic with shifting read/write bias and rare resets
        for (int blk = 0; blk < 12; blk++) begin
            wr_pct = int'($urandom_range(20, 90));
            rd_pct = int'($urandom_range(20, 90));
            for (int c = 0; c < 200; c++) begin
                step($urandom_range(0, 199) == 0,
                     $urandom_range(0, 99) < wr_pct,
                     8'($urandom),
                     $urandom_range(0, 99) < rd_pct);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_asy_fifo_core
`default_nettype wire
